// File: rtl/spi_seq_pkg.sv
// Shared definitions for spi_master_sequencer: FSM state encoding, length code and default timings.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_RUN   = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_RESP  = 3'd5
  } seq_state_t;

  localparam logic [3:0] SPI_LEN_32 = 4'hF;

  localparam int CS_SETUP_DEF = 2;
  localparam int CS_HOLD_DEF  = 2;
  localparam int MIN_GAP_DEF  = 2;
  localparam int TIMEOUT_DEF  = 4096;

  localparam int CNT_W  = 16;
  localparam int DATA_W = 32;

endpackage

// File: rtl/spi_master_sequencer.sv
// Command sequencer in front of spi_master_control: CS_N framing, spi_start hold, response capture.
// Optional spi_end watchdog is compiled in when SPI_SEQ_TIMEOUT_EN is defined.
module spi_master_sequencer
  import spi_seq_pkg::*;
#(
  parameter int CS_SETUP = CS_SETUP_DEF,
  parameter int CS_HOLD  = CS_HOLD_DEF,
  parameter int MIN_GAP  = MIN_GAP_DEF
`ifdef SPI_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_len,
  input  logic [3:0]        req_period,
  input  logic              req_loop,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              SPI_CS_N,
  output logic              spi_start,
  output logic [3:0]        spi_len,
  output logic [3:0]        spi_period,
  output logic              spi_loop,
  output logic [DATA_W-1:0] spi_odata,
  input  logic              spi_end,
  input  logic [DATA_W-1:0] spi_idata
);

  // Counter reload values; each phase ends on the cycle the counter reads zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((MIN_GAP > CS_HOLD) ? (MIN_GAP - CS_HOLD) : 0);
`ifdef SPI_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT - 1);
`endif

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_cs_n;
  logic              w_cs_n_nxt;
  logic              r_start;
  logic              w_start_nxt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              w_accept;
  logic              w_capture;
  logic              w_rsp_set;
  logic              w_rsp_clr;
  logic [3:0]        r_len;
  logic [3:0]        r_period;
  logic              r_loop;
  logic [DATA_W-1:0] r_odata;
  logic [DATA_W-1:0] r_rdata;
`ifdef SPI_SEQ_TIMEOUT_EN
  logic              w_abort;
  logic              r_err;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = sat_dec(r_cnt);
    w_cs_n_nxt  = r_cs_n;
    w_start_nxt = r_start;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_rsp_set   = 1'b0;
    w_rsp_clr   = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
    w_abort     = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_accept    = 1'b1;
          w_cs_n_nxt  = 1'b0;
          w_cnt_nxt   = SETUP_LD;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == '0) begin
          w_start_nxt = 1'b1;
          w_state_nxt = ST_RUN;
`ifdef SPI_SEQ_TIMEOUT_EN
          w_cnt_nxt   = TMO_LD;
`endif
        end
      end
      ST_RUN: begin
        if (spi_end) begin
          w_capture   = 1'b1;
          w_start_nxt = 1'b0;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = ST_HOLD;
        end
`ifdef SPI_SEQ_TIMEOUT_EN
        else if (r_cnt == '0) begin
          w_abort     = 1'b1;
          w_start_nxt = 1'b0;
          w_cnt_nxt   = HOLD_LD;
          w_state_nxt = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_cs_n_nxt  = 1'b1;
          w_cnt_nxt   = GAP_LD;
          w_state_nxt = ST_GAP;
        end
      end
      // The master only leaves WAIT once it has seen spi_start low, so spi_end gates the exit too.
      ST_GAP: begin
        if ((r_cnt == '0) && !spi_end) begin
          w_rsp_set   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_clr   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cs_n_nxt  = 1'b1;
        w_start_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cs_n      <= 1'b1;
      r_start     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_start     <= w_start_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      if (w_rsp_set) begin
        r_rsp_valid <= 1'b1;
      end else if (w_rsp_clr) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Request fields and the response word also clear on reset so a reset drops any stale response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len    <= '0;
      r_period <= '0;
      r_loop   <= 1'b0;
      r_odata  <= '0;
      r_rdata  <= '0;
`ifdef SPI_SEQ_TIMEOUT_EN
      r_err    <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_len    <= req_len;
        r_period <= req_period;
        r_loop   <= req_loop;
        r_odata  <= req_wdata;
      end
      if (w_capture) begin
        r_rdata <= spi_idata;
`ifdef SPI_SEQ_TIMEOUT_EN
        r_err   <= 1'b0;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
`endif
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rdata;
  assign SPI_CS_N   = r_cs_n;
  assign spi_start  = r_start;
  assign spi_len    = r_len;
  assign spi_period = r_period;
  assign spi_loop   = r_loop;
  assign spi_odata  = r_odata;
`ifdef SPI_SEQ_TIMEOUT_EN
  assign rsp_err    = r_err;
`else
  assign rsp_err    = 1'b0;
`endif

endmodule
